// File: rtl/l0_seq_ctrl_pkg.sv
// l0_seq_ctrl_pkg: FSM state and version encodings shared by the L0 sequencer.
package l0_seq_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_DRAIN,
        S_TAIL,
        S_DONE
    } state_t;
    localparam logic VER_FLAT = 1'b0;
    localparam logic VER_SKEW = 1'b1;
endpackage

// File: rtl/l0_seq_cnt.sv
// l0_seq_cnt: loadable up-counter flagging when the count equals tc_val.
module l0_seq_cnt #(
    parameter int w = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic         en,
    input  logic [w-1:0] d,
    input  logic [w-1:0] tc_val,
    output logic         tc
);
    logic [w-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= ld ? d : en ? cnt + w'(1) : cnt;
    assign tc = cnt == tc_val;
endmodule

// File: rtl/l0_seq_ctrl.sv
// l0_seq_ctrl: fills the L0 row FIFOs from SRAM, then drains them into the PE array.
module l0_seq_ctrl
    import l0_seq_ctrl_pkg::*;
#(
    parameter int row   = 8,
    parameter int depth = 64,
    parameter int aw    = 11,
    parameter int cw    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          version_in,
    input  logic [cw-1:0] num_vec,
    input  logic [aw-1:0] base_addr,
    input  logic          l0_full,
    output logic          sram_rd,
    output logic [aw-1:0] sram_addr,
    output logic          l0_wr,
    output logic          l0_rd,
    output logic          l0_version,
    output logic          busy,
    output logic          done
);
    localparam int tw = $clog2(row + 1);
    state_t state, nxt;
    logic acc, room, iss_tc, rd_tc, tail_tc;
    logic [cw-1:0] num_q;
    logic [cw:0] occ;
    assign acc = start && state == S_IDLE;
    // l0_wr doubles as the in-flight flag: it is last cycle's sram_rd
    assign room = (occ + (cw+1)'(l0_wr)) < (cw+1)'(depth);
    assign sram_rd = state == S_FILL && !iss_tc && room && !l0_full;
    assign l0_rd = state == S_DRAIN;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = !start ? S_IDLE : num_vec == '0 ? S_DONE : S_FILL;
            S_FILL:  nxt = iss_tc ? S_WAIT : S_FILL;
            S_WAIT:  nxt = S_DRAIN;
            S_DRAIN: nxt = !rd_tc ? S_DRAIN : l0_version == VER_SKEW ? S_TAIL : S_DONE;
            S_TAIL:  nxt = tail_tc ? S_DONE : S_TAIL;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            num_q      <= '0;
            l0_version <= VER_FLAT;
            sram_addr  <= '0;
            l0_wr      <= 1'b0;
            occ        <= '0;
        end else begin
            num_q      <= acc ? num_vec : num_q;
            l0_version <= acc ? version_in : l0_version;
            sram_addr  <= acc ? base_addr : sram_rd ? sram_addr + aw'(1) : sram_addr;
            l0_wr      <= sram_rd;
            occ        <= occ + (cw+1)'(l0_wr) - (cw+1)'(l0_rd);
        end
    l0_seq_cnt #(.w(cw)) u_iss (
        .clk(clk), .reset(reset), .ld(acc), .en(sram_rd),
        .d('0), .tc_val(num_q), .tc(iss_tc)
    );
    // terminal on the last read so DRAIN lasts exactly num_vec cycles
    l0_seq_cnt #(.w(cw)) u_rd (
        .clk(clk), .reset(reset), .ld(acc), .en(l0_rd),
        .d('0), .tc_val(num_q - cw'(1)), .tc(rd_tc)
    );
    l0_seq_cnt #(.w(tw)) u_tail (
        .clk(clk), .reset(reset), .ld(acc), .en(state == S_TAIL),
        .d('0), .tc_val(tw'(row - 1)), .tc(tail_tc)
    );
endmodule

// File: tb/tb_l0_seq_ctrl.sv
// tb_l0_seq_ctrl: scoreboard bench for the L0 fill/drain sequencer.
module tb_l0_seq_ctrl;
    localparam int ROW = 8, DEPTH = 64, AW = 11, CW = 7;
    logic clk = 0, reset = 0, start = 0, version_in = 0, l0_full = 0;
    logic [CW-1:0] num_vec = '0;
    logic [AW-1:0] base_addr = '0;
    logic sram_rd, l0_wr, l0_rd, l0_version, busy, done;
    logic [AW-1:0] sram_addr;
    int checks = 0, errors = 0;
    int cyc = 0, n_srd = 0, n_wr = 0, n_lrd = 0, n_done = 0, n_busy = 0;
    int cur_run = 0, last_run = 0, last_rd_cyc = 0, done_cyc = 0;
    logic prev_rd = 0;
    logic [AW-1:0] exp_q[$];

    l0_seq_ctrl #(.row(ROW), .depth(DEPTH), .aw(AW), .cw(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .version_in(version_in),
        .num_vec(num_vec), .base_addr(base_addr), .l0_full(l0_full),
        .sram_rd(sram_rd), .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .l0_version(l0_version), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // monitor: pops expected addresses and tracks event counts
    always @(negedge clk) begin
        logic [AW-1:0] e;
        cyc++;
        if (!reset) begin
            prev_rd = 0;
        end else begin
            checks++;
            if (l0_wr !== prev_rd) begin
                errors++;
                $display("FAIL wr_align: l0_wr=%b expected %b (cycle %0d)", l0_wr, prev_rd, cyc);
            end
            if (l0_full) begin
                checks++;
                if (sram_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_while_full: sram_rd=%b expected 0 (cycle %0d)", sram_rd, cyc);
                end
            end
            if (sram_rd === 1'b1) begin
                n_srd++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_addr: unexpected read at %h, expected none", sram_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (sram_addr !== e) begin
                        errors++;
                        $display("FAIL sram_addr: got %h expected %h", sram_addr, e);
                    end
                end
            end
            if (l0_rd === 1'b1) begin
                cur_run++;
                last_rd_cyc = cyc;
            end else if (cur_run > 0) begin
                last_run = cur_run;
                cur_run = 0;
            end
            prev_rd = sram_rd;
            n_wr += int'(l0_wr);
            n_lrd += int'(l0_rd);
            n_busy += int'(busy);
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_start(input logic v, input int n, input logic [AW-1:0] b, output int sc);
        for (int i = 0; i < n; i++) exp_q.push_back(b + AW'(i));
        @(posedge clk);
        #1;
        version_in = v;
        num_vec = CW'(n);
        base_addr = b;
        start = 1;
        sc = cyc + 1;
        @(posedge clk);
        #1;
        start = 0;
        version_in = ~v;
        num_vec = 7'd5;
        base_addr = 11'h3AA;
    endtask

    task automatic wait_done(input int d0, output bit to);
        int t = 0;
        while (n_done == d0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        to = (n_done == d0);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({sram_rd, sram_addr, l0_wr, l0_rd, l0_version, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b addr=%h wr=%b lrd=%b ver=%b busy=%b done=%b, expected all 0",
                     sram_rd, sram_addr, l0_wr, l0_rd, l0_version, busy, done);
        end
        @(negedge clk);
        #2 reset = 1;
    endtask

    task automatic test_flat;
        int sc, s0 = n_srd, w0 = n_wr, r0 = n_lrd, d0 = n_done;
        bit to;
        run_start(1'b0, 8, 11'h010, sc);
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL flat_timeout: no done, expected done"); end
        checks++;
        if (done_cyc - sc != 19) begin errors++; $display("FAIL flat_latency: got %0d expected 19", done_cyc - sc); end
        checks++;
        if (n_srd - s0 != 8 || n_wr - w0 != 8) begin
            errors++; $display("FAIL flat_counts: rd=%0d wr=%0d expected 8/8", n_srd - s0, n_wr - w0);
        end
        checks++;
        if (n_lrd - r0 != 8 || last_run != 8) begin
            errors++; $display("FAIL flat_drain: l0_rd=%0d run=%0d expected 8 consecutive", n_lrd - r0, last_run);
        end
        checks++;
        if (l0_version !== 1'b0) begin errors++; $display("FAIL flat_version: got %b expected 0", l0_version); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flat_addrs: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_skew;
        int sc, r0 = n_lrd, d0 = n_done;
        bit to;
        run_start(1'b1, 4, 11'h100, sc);
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL skew_timeout: no done, expected done"); end
        checks++;
        if (done_cyc - sc != 19) begin errors++; $display("FAIL skew_latency: got %0d expected 19", done_cyc - sc); end
        checks++;
        if (n_lrd - r0 != 4 || last_run != 4) begin
            errors++; $display("FAIL skew_drain: l0_rd=%0d run=%0d expected 4", n_lrd - r0, last_run);
        end
        checks++;
        if (done_cyc - last_rd_cyc != ROW + 1) begin
            errors++; $display("FAIL skew_tail: got %0d expected %0d", done_cyc - last_rd_cyc, ROW + 1);
        end
        repeat (3) @(posedge clk);
        checks++;
        if (l0_version !== 1'b1) begin errors++; $display("FAIL skew_version: got %b expected 1", l0_version); end
    endtask

    task automatic test_stall;
        int sc, t = 0, s0 = n_srd, w0 = n_wr, r0 = n_lrd, d0 = n_done;
        bit to;
        run_start(1'b0, 64, 11'h7F0, sc);
        while (n_srd - s0 < 30 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1 l0_full = 1;
        repeat (5) @(posedge clk);
        #1 l0_full = 0;
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL stall_timeout: no done, expected done"); end
        checks++;
        if (done_cyc - sc != 136) begin errors++; $display("FAIL stall_latency: got %0d expected 136", done_cyc - sc); end
        checks++;
        if (n_srd - s0 != 64 || n_wr - w0 != 64 || n_lrd - r0 != 64) begin
            errors++;
            $display("FAIL stall_counts: rd=%0d wr=%0d l0rd=%0d expected 64 each", n_srd - s0, n_wr - w0, n_lrd - r0);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_addrs: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_zero;
        int sc, s0 = n_srd, w0 = n_wr, r0 = n_lrd, b0 = n_busy, d0 = n_done;
        bit to;
        run_start(1'b0, 0, 11'h050, sc);
        wait_done(d0, to);
        repeat (2) @(posedge clk);
        checks++;
        if (to) begin errors++; $display("FAIL zero_timeout: no done, expected done"); end
        checks++;
        if (done_cyc - sc != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", done_cyc - sc); end
        checks++;
        if (n_srd != s0 || n_wr != w0 || n_lrd != r0) begin
            errors++; $display("FAIL zero_activity: rd=%0d wr=%0d l0rd=%0d expected 0", n_srd - s0, n_wr - w0, n_lrd - r0);
        end
        checks++;
        if (n_busy - b0 != 1) begin errors++; $display("FAIL zero_busy: got %0d expected 1", n_busy - b0); end
    endtask

    task automatic test_start_in_drain;
        int sc, t = 0, s0 = n_srd, r0 = n_lrd, d0 = n_done;
        bit to;
        run_start(1'b0, 6, 11'h200, sc);
        while (n_lrd == r0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        version_in = 1;
        num_vec = 7'd3;
        base_addr = 11'h555;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_done(d0, to);
        repeat (30) @(posedge clk);
        checks++;
        if (to) begin errors++; $display("FAIL drain_timeout: no done, expected done"); end
        checks++;
        if (done_cyc - sc != 15) begin errors++; $display("FAIL drain_latency: got %0d expected 15", done_cyc - sc); end
        checks++;
        if (n_done - d0 != 1) begin errors++; $display("FAIL drain_dones: got %0d expected 1", n_done - d0); end
        checks++;
        if (n_srd - s0 != 6 || n_lrd - r0 != 6) begin
            errors++; $display("FAIL drain_counts: rd=%0d l0rd=%0d expected 6/6", n_srd - s0, n_lrd - r0);
        end
        checks++;
        if (l0_version !== 1'b0 || sram_addr !== 11'h206) begin
            errors++; $display("FAIL drain_latched: ver=%b addr=%h expected 0/206", l0_version, sram_addr);
        end
    endtask

    task automatic test_abort;
        int sc, t = 0, s0 = n_srd, d0 = n_done;
        bit to;
        run_start(1'b1, 10, 11'h020, sc);
        while (n_srd - s0 < 3 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #3 reset = 0;
        #1;
        checks++;
        if ({sram_rd, sram_addr, l0_wr, l0_rd, l0_version, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: rd=%b addr=%h wr=%b lrd=%b ver=%b busy=%b, expected all 0",
                     sram_rd, sram_addr, l0_wr, l0_rd, l0_version, busy);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1;
        repeat (2) @(posedge clk);
        checks++;
        if (n_done != d0) begin errors++; $display("FAIL abort_done: got %0d dones expected 0", n_done - d0); end
        s0 = n_srd;
        d0 = n_done;
        run_start(1'b0, 5, 11'h030, sc);
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL abort_rerun_timeout: no done, expected done"); end
        checks++;
        if (done_cyc - sc != 13 || n_srd - s0 != 5) begin
            errors++; $display("FAIL abort_rerun: latency=%0d reads=%0d expected 13/5", done_cyc - sc, n_srd - s0);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_addrs: %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_skew();
        test_stall();
        test_zero();
        test_start_in_drain();
        test_abort();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
